// File: rtl/delay_cal_pkg.sv
// delay_cal_pkg: shared widths, FSM states and result helper for the delay tap calibrator
`timescale 1ns/1ps
package delay_cal_pkg;
    localparam int TAP_W    = 3;
    localparam int NUM_TAPS = 8;

    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, SAMPLE, ACCUM, RECOVER, EVAL, DONE} state_t;

    function automatic logic [TAP_W-1:0] lowest_zero(input logic [NUM_TAPS-1:0] m);
        lowest_zero = TAP_W'(NUM_TAPS-1);
        for (int i = NUM_TAPS-1; i >= 0; i--)
            if (!m[i]) lowest_zero = TAP_W'(i);
    endfunction
endpackage

// File: rtl/delay_capture_sync.sv
// delay_capture_sync: two-flop capture of the asynchronous delay line output
`timescale 1ns/1ps
module delay_capture_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic cap1;

    // cap1 takes the measurement sample; cap2 gives it a cycle to resolve metastability
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap1 <= 1'b0;
            q    <= 1'b0;
        end else begin
            cap1 <= d;
            q    <= cap1;
        end
    end
endmodule

// File: rtl/delay_tap_calibrator.sv
// delay_tap_calibrator: sweeps all delay taps, launching edges and scoring one-period arrival by majority
`timescale 1ns/1ps
module delay_tap_calibrator
    import delay_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int NUM_AVG        = 8,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                line_in_o,
    output logic [TAP_W-1:0]    sel_o,
    input  logic                line_out_i,
    output logic                busy,
    output logic                done,
    output logic [NUM_TAPS-1:0] pass_map,
    output logic [TAP_W-1:0]    first_fail,
    output logic                all_pass
);
    localparam int CNT_MAX = (SETTLE_CYCLES > RECOVER_CYCLES) ? SETTLE_CYCLES : RECOVER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HIT_W   = $clog2(NUM_AVG + 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt;
    logic [HIT_W-1:0]      hits, trial;
    logic                  cap;
    logic [NUM_TAPS-1:0]   pm_n;

    delay_capture_sync u_cap (.clk(clk), .rst_n(rst_n), .d(line_out_i), .q(cap));

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    // next state and the pass map as it will look after scoring the current tap
    always_comb begin
        state_n      = state;
        pm_n         = pass_map;
        pm_n[sel_o]  = (int'(hits) * 2 > NUM_AVG);
        case (state)
            IDLE:    state_n = start ? SETTLE : IDLE;
            SETTLE:  state_n = (cnt == CNT_W'(SETTLE_CYCLES-1)) ? LAUNCH : SETTLE;
            LAUNCH:  state_n = SAMPLE;
            SAMPLE:  state_n = ACCUM;
            ACCUM:   state_n = RECOVER;
            RECOVER: state_n = (cnt != CNT_W'(RECOVER_CYCLES-1)) ? RECOVER :
                               (trial == HIT_W'(NUM_AVG)) ? EVAL : LAUNCH;
            EVAL:    state_n = (sel_o == TAP_W'(NUM_TAPS-1)) ? DONE : SETTLE;
            default: state_n = IDLE;
        endcase
    end

    // state, registered launch/select outputs, counters and results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_in_o  <= 1'b0;
            sel_o      <= '0;
            cnt        <= '0;
            hits       <= '0;
            trial      <= '0;
            pass_map   <= '0;
            first_fail <= '0;
            all_pass   <= 1'b0;
        end else begin
            state     <= state_n;
            line_in_o <= (state_n == LAUNCH);
            cnt       <= (state_n == state && (state == SETTLE || state == RECOVER)) ? cnt + 1'b1 : '0;
            case (state)
                IDLE: if (start) begin
                    sel_o      <= '0;
                    pass_map   <= '0;
                    first_fail <= '0;
                    all_pass   <= 1'b0;
                    trial      <= '0;
                    hits       <= '0;
                end
                ACCUM: begin
                    trial <= trial + 1'b1;
                    hits  <= hits + HIT_W'(cap);
                end
                EVAL: begin
                    pass_map <= pm_n;
                    hits     <= '0;
                    trial    <= '0;
                    if (sel_o == TAP_W'(NUM_TAPS-1)) begin
                        first_fail <= lowest_zero(pm_n);
                        all_pass   <= &pm_n;
                    end else begin
                        sel_o <= sel_o + 1'b1;
                    end
                end
                DONE: sel_o <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_tap_calibrator.sv
// tb_delay_tap_calibrator: sweeps against a modelled delay line, scoring results through a scoreboard
`timescale 1ns/1ps
module tb_delay_tap_calibrator;
    localparam int L = 360;

    typedef struct {logic [7:0] pm; logic [2:0] ff; logic ap; int cyc;} exp_t;
    typedef struct {int mode; real d; logic [7:0] pm; logic [2:0] ff; logic ap;} vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       line_in_o, line_out_i, busy, done, all_pass;
    logic [2:0] sel_o, first_fail;
    logic [7:0] pass_map;

    int   checks = 0, errors = 0, cyc = 0, mode = 0, alt = 0;
    real  d_ns = 0.5;
    logic model = 1'b0;
    exp_t sb[$];
    exp_t e_m;
    vec_t vecs[5];
    int   launches[8];
    logic prev_line = 1'b0;
    logic [2:0] prev_sel = '0;

    delay_tap_calibrator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line_in_o(line_in_o), .sel_o(sel_o),
        .line_out_i(line_out_i), .busy(busy), .done(done), .pass_map(pass_map),
        .first_fail(first_fail), .all_pass(all_pass)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // delay line: every edge of line_in_o reappears sel*d ns later
    always @(line_in_o) begin
        automatic logic v  = line_in_o;
        automatic real  dl = real'(sel_o) * d_ns;
        fork
            #(dl) model = v;
        join_none
    end
    always @(posedge line_in_o) alt++;

    assign line_out_i = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (mode == 3) ? (model & alt[0]) : model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: select stability at launch, launches per tap, scoreboard pop on done
    always @(negedge clk) begin
        prev_line <= line_in_o;
        prev_sel  <= sel_o;
        if (!rst_n) begin
            foreach (launches[t]) launches[t] <= 0;
        end else begin
            if (line_in_o) begin
                chk("sel_stable", 32'(sel_o), 32'(prev_sel));
                if (!prev_line) launches[sel_o] <= launches[sel_o] + 1;
            end
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'(done), 0);
                else begin
                    e_m = sb.pop_front();
                    chk("pass_map", 32'(pass_map), 32'(e_m.pm));
                    chk("first_fail", 32'(first_fail), 32'(e_m.ff));
                    chk("all_pass", 32'(all_pass), 32'(e_m.ap));
                    chk("done_cycle", cyc, e_m.cyc);
                    foreach (launches[t]) chk($sformatf("launches_tap%0d", t), launches[t], 8);
                end
                foreach (launches[t]) launches[t] <= 0;
            end
        end
    end

    task automatic launch_sweep(input int m, input real d, input logic [7:0] pm, input logic [2:0] ff, input logic ap);
        mode = m;
        d_ns = d;
        @(posedge clk); #1;
        start = 1'b1;
        sb.push_back('{pm, ff, ap, cyc + 1 + L});
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_sb();
        int n = 0;
        while (sb.size() != 0 && n < L + 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_line_in", 32'(line_in_o), 0);
        chk("rst_sel", 32'(sel_o), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass_map", 32'(pass_map), 0);
        chk("rst_first_fail", 32'(first_fail), 0);
        chk("rst_all_pass", 32'(all_pass), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0.5, 8'hFF, 3'd7, 1'b1};
        vecs[1] = '{0, 3.0, 8'h0F, 3'd4, 1'b0};
        vecs[2] = '{1, 0.5, 8'h00, 3'd0, 1'b0};
        vecs[3] = '{2, 0.5, 8'hFF, 3'd7, 1'b1};
        vecs[4] = '{3, 0.5, 8'h00, 3'd0, 1'b0};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        foreach (vecs[i]) begin
            launch_sweep(vecs[i].mode, vecs[i].d, vecs[i].pm, vecs[i].ff, vecs[i].ap);
            wait_sb();
            repeat (3) @(posedge clk);
            #1;
            chk("hold_pass_map", 32'(pass_map), 32'(vecs[i].pm));
            chk("idle_busy", 32'(busy), 0);
        end
        launch_sweep(0, 0.5, 8'hFF, 3'd7, 1'b1);
        repeat (48) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_ignored_start", 32'(busy), 1);
        wait_sb();
        launch_sweep(0, 3.0, 8'h0F, 3'd4, 1'b0);
        repeat (98) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        begin
            int dn = 0;
            repeat (L + 20) begin
                @(negedge clk);
                if (done) dn++;
            end
            chk("no_done_after_abort", dn, 0);
        end
        launch_sweep(0, 3.0, 8'h0F, 3'd4, 1'b0);
        wait_sb();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
